keypad_entry: RTL and testbench
===============================

KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 The block SHALL expose parameter TIMEOUT_CYC, default 1000, which is the number of idle cycles after which a partial entry is abandoned.
REQ-002 The block SHALL expose parameter HOLDOFF_CYC, default 16, which is the number of cycles after a submit during which all keys are ignored.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port key_valid, input, 1 bit: one-cycle strobe qualifying key_code.
REQ-006 The block SHALL have port key_code, input, 4 bits: hex digit 0x0-0xF.
REQ-007 The block SHALL have port key_clr, input, 1 bit: one-cycle clear strobe.
REQ-008 The block SHALL have port key_ent, input, 1 bit: one-cycle submit strobe.
REQ-009 The block SHALL have port user_in, input, 2 bits: user select, latched with the first digit of an entry.
REQ-010 The block SHALL have port PassIn, output, 12 bits: submitted code, first digit in [11:8]; drives the lock's code input.
REQ-011 The block SHALL have port Enter, output, 1 bit: one-cycle submit strobe to the lock.
REQ-012 The block SHALL have port user, output, 2 bits: user latched for the submitted code.
REQ-013 The block SHALL have port digits, output, 2 bits: number of digits currently collected (0-3).
REQ-014 The block SHALL have port busy, output, 1 bit: high in SUBMIT and HOLDOFF.
REQ-015 The block SHALL have port err, output, 1 bit: one-cycle pulse on a short entry.
REQ-016 The block SHALL have port ovf, output, 1 bit: one-cycle pulse on a digit entered while FULL.
REQ-017 The block SHALL have port tmo, output, 1 bit: one-cycle pulse on entry timeout.

Function
REQ-018 The FSM SHALL have states IDLE, COLLECT, FULL, SUBMIT and HOLDOFF, all registered.
REQ-019 Event priority within a cycle SHALL be key_clr > key_ent > key_valid > timeout.
REQ-020 In IDLE, key_valid SHALL load key_code into working register bits [3:0], set digits=1, latch user_in, and move to COLLECT, all visible on the next cycle.
REQ-021 In COLLECT, key_valid SHALL shift the working register left by 4, insert key_code at [3:0], and increment digits; when digits reaches 3 the FSM SHALL move to FULL.
REQ-022 In FULL, key_valid SHALL leave the working register and digits unchanged and pulse ovf for one cycle.
REQ-023 key_ent in FULL SHALL move the FSM to SUBMIT on the next cycle.
REQ-024 In SUBMIT, PassIn SHALL equal the working register, user SHALL equal the latched user, and Enter SHALL be 1 for exactly this one cycle.
REQ-025 key_ent in IDLE or COLLECT (digits < 3) SHALL pulse err for one cycle on the next cycle, clear the working register and digits, and go to IDLE; Enter SHALL remain 0.
REQ-026 key_clr in IDLE, COLLECT or FULL SHALL clear the working register and digits and go to IDLE on the next cycle, with no err pulse.
REQ-027 From SUBMIT the FSM SHALL move to HOLDOFF and remain there exactly HOLDOFF_CYC cycles before returning to IDLE; key_valid, key_ent and key_clr SHALL be ignored in SUBMIT and HOLDOFF.
REQ-028 PassIn and user SHALL update only on entry to SUBMIT and SHALL hold that value until the next SUBMIT.
REQ-029 The idle counter SHALL reset on any accepted key in COLLECT or FULL and increment otherwise.
REQ-030 When the idle counter reaches TIMEOUT_CYC-1, the block SHALL pulse tmo, clear the working register and digits, and go to IDLE.
REQ-031 The idle counter SHALL be held at 0 in IDLE, SUBMIT and HOLDOFF.
REQ-032 The HOLDOFF counter SHALL be sized for HOLDOFF_CYC and SHALL NOT wrap.

Reset
REQ-033 When reset_n=0 at a clock edge, the block SHALL be in IDLE on the next cycle with PassIn=0x000, user=0, digits=0, Enter=0, busy=0, err=0, ovf=0, tmo=0, and both counters at 0.
REQ-034 Reset SHALL override any in-progress entry, SUBMIT or HOLDOFF, including one asserted in the same cycle as Enter, and SHALL produce no further Enter pulse.

Verification
REQ-035 The bench SHALL cover: keys 0x1,0x1,0x1 then key_ent, user_in=3 -> exactly one Enter pulse with PassIn=0x111 and user=3, busy for 1+HOLDOFF_CYC cycles.
REQ-036 The bench SHALL cover: keys 0xF,0x1,0xA, a fourth key 0x9, then key_ent -> ovf pulse on the fourth key, PassIn=0xF1A.
REQ-037 The bench SHALL cover: keys 0x0,0xA then key_ent -> err pulse, no Enter, digits=0, and PassIn unchanged from the previous submit.
REQ-038 The bench SHALL cover: key 0x1 then TIMEOUT_CYC idle cycles -> tmo pulse, digits=0; a following 0x9,0x9,0x9 + key_ent -> PassIn=0x999.
REQ-039 The bench SHALL cover: key_clr and key_ent in the same cycle while FULL -> clear wins: IDLE, no Enter, no err.
REQ-040 The bench SHALL cover: keys 0x1,0x8,0x8 + key_ent, reset_n=0 during HOLDOFF, then keys pressed -> all outputs at reset values; keys accepted once reset_n=1.

Source files
------------

// File: rtl/keypad_if.sv
// Keypad-to-lock bundle: key strobes and user select in, submitted code and status out.
// master drives the keys (keypad side); slave is the entry block.
interface keypad_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_clr;
  logic        key_ent;
  logic [1:0]  user_in;
  logic [11:0] PassIn;
  logic        Enter;
  logic [1:0]  user;
  logic [1:0]  digits;
  logic        busy;
  logic        err;
  logic        ovf;
  logic        tmo;

  modport master (
    output key_valid, key_code, key_clr, key_ent, user_in,
    input  PassIn, Enter, user, digits, busy, err, ovf, tmo
  );

  modport slave (
    input  key_valid, key_code, key_clr, key_ent, user_in,
    output PassIn, Enter, user, digits, busy, err, ovf, tmo
  );
endinterface

// File: rtl/keypad_entry.sv
// Collects up to three hex digits from a keypad and submits them to the lock as one code,
// with clear, short-entry error, overflow, idle timeout and a post-submit holdoff.
//
// Handshake: every key input is a one-cycle strobe with no back-pressure. A strobe that
// arrives in SUBMIT or HOLDOFF (busy=1) is dropped. Within one cycle the events are
// prioritised clr > ent > valid > timeout. Enter is a one-cycle strobe to the lock, and
// PassIn/user are stable from that cycle until the next submit.
module keypad_entry #(
  parameter int TIMEOUT_CYC = 1000,
  parameter int HOLDOFF_CYC = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  keypad_if.slave    kp,
  output logic [2:0] dbg_state
);

  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  localparam int HW = $clog2(HOLDOFF_CYC + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYC - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    FULL    = 3'd2,
    SUBMIT  = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [11:0]   work, work_n, pass_q, pass_n;
  logic [1:0]    digits_q, digits_n, user_q, user_n, ulatch, ulatch_n;
  logic [IW-1:0] idle_cnt, idle_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic          err_q, err_n, ovf_q, ovf_n, tmo_q, tmo_n;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      work     <= '0;
      pass_q   <= '0;
      digits_q <= '0;
      user_q   <= '0;
      ulatch   <= '0;
      idle_cnt <= '0;
      hold_cnt <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state    <= state_n;
      work     <= work_n;
      pass_q   <= pass_n;
      digits_q <= digits_n;
      user_q   <= user_n;
      ulatch   <= ulatch_n;
      idle_cnt <= idle_n;
      hold_cnt <= hold_n;
      err_q    <= err_n;
      ovf_q    <= ovf_n;
      tmo_q    <= tmo_n;
    end
  end

  always_comb begin
    state_n  = state;
    work_n   = work;
    pass_n   = pass_q;
    digits_n = digits_q;
    user_n   = user_q;
    ulatch_n = ulatch;
    idle_n   = '0;
    hold_n   = '0;
    err_n    = 1'b0;
    ovf_n    = 1'b0;
    tmo_n    = 1'b0;
    case (state)
      IDLE: begin
        if (kp.key_clr) begin
          work_n   = '0;
          digits_n = '0;
        end else if (kp.key_ent) begin
          err_n    = 1'b1;
          work_n   = '0;
          digits_n = '0;
        end else if (kp.key_valid) begin
          work_n   = {8'h00, kp.key_code};
          digits_n = 2'd1;
          ulatch_n = kp.user_in;
          state_n  = COLLECT;
        end
      end
      COLLECT, FULL: begin
        if (kp.key_clr) begin
          work_n   = '0;
          digits_n = '0;
          state_n  = IDLE;
        end else if (kp.key_ent) begin
          work_n   = '0;
          digits_n = '0;
          if (state == FULL) begin
            pass_n  = work;
            user_n  = ulatch;
            state_n = SUBMIT;
          end else begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end else if (kp.key_valid) begin
          // A fourth digit is refused but still counts as activity for the timeout.
          if (state == FULL) begin
            ovf_n = 1'b1;
          end else begin
            work_n   = {work[7:0], kp.key_code};
            digits_n = digits_q + 2'd1;
            if (digits_q == 2'd2) state_n = FULL;
          end
        end else if (idle_cnt == IDLE_LAST) begin
          tmo_n    = 1'b1;
          work_n   = '0;
          digits_n = '0;
          state_n  = IDLE;
        end else begin
          idle_n = idle_cnt + 1'b1;
        end
      end
      SUBMIT: state_n = HOLDOFF;
      HOLDOFF: begin
        if (hold_cnt == HOLD_LAST) state_n = IDLE;
        else hold_n = hold_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign kp.PassIn = pass_q;
  assign kp.user   = user_q;
  assign kp.digits = digits_q;
  assign kp.Enter  = (state == SUBMIT);
  assign kp.busy   = (state == SUBMIT) || (state == HOLDOFF);
  assign kp.err    = err_q;
  assign kp.ovf    = ovf_q;
  assign kp.tmo    = tmo_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: submit, overflow, short entry, timeout, clear/ent race
// and reset during holdoff, with hand-computed expected values.
module tb_keypad_entry;
  localparam int T = 20;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] dbg_state;
  int         total = 0;
  int         bad = 0;

  keypad_if kp ();

  keypad_entry #(.TIMEOUT_CYC(T), .HOLDOFF_CYC(H)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .kp        (kp.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Strobe helpers: drive on a falling edge, return on the falling edge after the
  // sampling rising edge so the registered response is already visible.
  task automatic key(input logic [3:0] c);
    @(negedge clk);
    kp.key_valid = 1'b1;
    kp.key_code  = c;
    @(negedge clk);
    kp.key_valid = 1'b0;
  endtask

  task automatic ent();
    @(negedge clk);
    kp.key_ent = 1'b1;
    @(negedge clk);
    kp.key_ent = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (kp.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_bound", 32'(kp.busy), 32'd0);
  endtask

  initial begin
    int busy_n, enter_n;
    kp.key_valid = 1'b0;
    kp.key_code  = 4'h0;
    kp.key_clr   = 1'b0;
    kp.key_ent   = 1'b0;
    kp.user_in   = 2'd0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_passin", 32'(kp.PassIn), 32'h000);
    chk("rst_user", 32'(kp.user), 32'd0);
    chk("rst_digits", 32'(kp.digits), 32'd0);
    chk("rst_flags", {28'd0, kp.Enter, kp.busy, kp.err, kp.ovf | kp.tmo}, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    reset_n = 1'b1;

    // 1,1,1 + ent, user 3
    kp.user_in = 2'd3;
    key(4'h1);
    kp.user_in = 2'd0;
    chk("t1_digits1", 32'(kp.digits), 32'd1);
    key(4'h1);
    key(4'h1);
    chk("t1_digits3", 32'(kp.digits), 32'd3);
    ent();
    chk("t1_enter", 32'(kp.Enter), 32'd1);
    chk("t1_passin", 32'(kp.PassIn), 32'h111);
    chk("t1_user", 32'(kp.user), 32'd3);
    busy_n = 0;
    enter_n = 0;
    while (kp.busy && busy_n < 100) begin
      busy_n++;
      if (kp.Enter) enter_n++;
      @(negedge clk);
    end
    chk("t1_busy_cycles", 32'(busy_n), 32'(1 + H));
    chk("t1_enter_count", 32'(enter_n), 32'd1);
    chk("t1_digits_after", 32'(kp.digits), 32'd0);

    // F,1,A then overflow 9
    key(4'hF);
    key(4'h1);
    key(4'hA);
    key(4'h9);
    chk("t2_ovf", 32'(kp.ovf), 32'd1);
    chk("t2_digits", 32'(kp.digits), 32'd3);
    @(negedge clk);
    chk("t2_ovf_once", 32'(kp.ovf), 32'd0);
    ent();
    chk("t2_passin", 32'(kp.PassIn), 32'hF1A);
    chk("t2_enter", 32'(kp.Enter), 32'd1);
    wait_idle();

    // short entry 0,A + ent
    key(4'h0);
    key(4'hA);
    ent();
    chk("t3_err", 32'(kp.err), 32'd1);
    chk("t3_enter", 32'(kp.Enter), 32'd0);
    chk("t3_digits", 32'(kp.digits), 32'd0);
    chk("t3_passin", 32'(kp.PassIn), 32'hF1A);
    @(negedge clk);
    chk("t3_err_once", 32'(kp.err), 32'd0);

    // timeout after one digit
    key(4'h1);
    repeat (T - 1) @(negedge clk);
    chk("t4_tmo_early", 32'(kp.tmo), 32'd0);
    chk("t4_digits_early", 32'(kp.digits), 32'd1);
    @(negedge clk);
    chk("t4_tmo", 32'(kp.tmo), 32'd1);
    chk("t4_digits", 32'(kp.digits), 32'd0);
    key(4'h9);
    key(4'h9);
    key(4'h9);
    ent();
    chk("t4_passin", 32'(kp.PassIn), 32'h999);
    wait_idle();

    // clr and ent together while FULL
    key(4'h1);
    key(4'h2);
    key(4'h3);
    @(negedge clk);
    kp.key_clr = 1'b1;
    kp.key_ent = 1'b1;
    @(negedge clk);
    kp.key_clr = 1'b0;
    kp.key_ent = 1'b0;
    chk("t5_enter", 32'(kp.Enter), 32'd0);
    chk("t5_err", 32'(kp.err), 32'd0);
    chk("t5_digits", 32'(kp.digits), 32'd0);
    chk("t5_state", 32'(dbg_state), 32'd0);
    chk("t5_passin", 32'(kp.PassIn), 32'h999);

    // 1,8,8 + ent, reset during holdoff
    kp.user_in = 2'd1;
    key(4'h1);
    key(4'h8);
    key(4'h8);
    ent();
    chk("t6_passin", 32'(kp.PassIn), 32'h188);
    chk("t6_user", 32'(kp.user), 32'd1);
    repeat (2) @(negedge clk);
    chk("t6_busy_holdoff", 32'(kp.busy), 32'd1);
    reset_n = 1'b0;
    key(4'h7);
    ent();
    chk("t6_rst_passin", 32'(kp.PassIn), 32'h000);
    chk("t6_rst_user", 32'(kp.user), 32'd0);
    chk("t6_rst_digits", 32'(kp.digits), 32'd0);
    chk("t6_rst_flags", {28'd0, kp.Enter, kp.busy, kp.err, kp.ovf | kp.tmo}, 32'd0);
    reset_n = 1'b1;
    key(4'h5);
    chk("t6_accept_digits", 32'(kp.digits), 32'd1);
    key(4'h6);
    key(4'h7);
    ent();
    chk("t6_passin2", 32'(kp.PassIn), 32'h567);
    chk("t6_user2", 32'(kp.user), 32'd1);

    // reset in the same cycle as Enter
    reset_n = 1'b0;
    @(negedge clk);
    chk("t7_enter", 32'(kp.Enter), 32'd0);
    chk("t7_busy", 32'(kp.busy), 32'd0);
    chk("t7_passin", 32'(kp.PassIn), 32'h000);
    reset_n = 1'b1;
    repeat (H + 2) @(negedge clk);
    chk("t7_no_enter", 32'(kp.Enter), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
